raster_addr_gen: RTL and testbench
==================================

RASTER_ADDR_GEN -- requirements
Module: raster_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20, frame-buffer address width.
REQ-002 SHALL have parameter COL_BITS, default 10, column counter width.
REQ-003 SHALL have parameter ROW_BITS, default 9, row counter width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle frame request.
REQ-007 SHALL have port img_width  in  COL_BITS  pixels per line.
REQ-008 SHALL have port img_height  in  ROW_BITS  lines per frame.
REQ-009 SHALL have port base_addr  in  ADDR_BITS  address of pixel (0,0).
REQ-010 SHALL have port addr_ready  in  1  consumer accepts current address.
REQ-011 SHALL have port addr_valid  out  1  addr/col/row are valid.
REQ-012 SHALL have port addr  out  ADDR_BITS  current pixel address.
REQ-013 SHALL have port col  out  COL_BITS  current column.
REQ-014 SHALL have port row  out  ROW_BITS  current row.
REQ-015 SHALL have port line_end  out  1  high with valid on the last column of each line.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after the final beat.
REQ-017 SHALL have port busy  out  1  high in RUN and DONE.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on accepted final beat, DONE->IDLE unconditionally next cycle.
REQ-019 SHALL latch img_width, img_height, base_addr on the start cycle; later input changes have no effect within the frame.
REQ-020 SHALL assert addr_valid the cycle after start, with addr=base_addr, col=0, row=0.
REQ-021 SHALL count a beat only when addr_valid && addr_ready; addr/col/row SHALL hold stable while addr_valid && !addr_ready.
REQ-022 SHALL scan in raster order: col increments per beat; at col=width-1 col wraps to 0 and row increments.
REQ-023 SHALL compute addr incrementally (running pointer +1 per beat, no multiplier), so addr = base_addr + row*width + col, modulo 2^ADDR_BITS.
REQ-024 SHALL treat the beat at col=width-1, row=height-1 as final; addr_valid SHALL deassert the cycle after it is accepted.
REQ-025 SHALL assert frame_done for exactly the DONE cycle; addr_valid SHALL be 0 in DONE and IDLE.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL go IDLE->DONE directly, with no beats, when the latched width or height is 0.
REQ-028 SHALL accept start on the IDLE cycle immediately after DONE.

Reset
REQ-029 SHALL, on rst, force IDLE and drive addr_valid, addr, col, row, line_end, frame_done and busy to 0 asynchronously, including mid-frame.
REQ-030 SHALL resume only on a fresh start after rst deasserts; no partial frame resumes.

Configuration
REQ-031 With RASTER_BORDER_FLAG_EN defined, SHALL add output border (1 bit), high with addr_valid when row=0, row=height-1, col=0 or col=width-1.
REQ-032 Without RASTER_BORDER_FLAG_EN, SHALL omit the border port and its logic entirely.

Structure
REQ-033 SHALL take the state enum (IDLE/RUN/DONE) and default width constants from shared package cartoon_pkg.
REQ-034 SHALL instantiate flex_counter twice, once for column and once for row, with the row counter enabled by the column rollover on an accepted beat.

Verification
REQ-035 Width 4, height 2, base 0x100, ready tied 1 -> 8 beats with addr 0x100..0x107 and line_end on beats 4 and 8; frame_done one cycle after beat 8.
REQ-036 Width 3, height 1, ready low 2 cycles on beat 2 -> addr 0x001 held 3 cycles; total 3 beats; no duplicates or skips.
REQ-037 start pulsed again mid-frame -> ignored; latched frame completes unchanged.
REQ-038 Width 0, height 5 -> no addr_valid; frame_done the cycle after start's edge.
REQ-039 rst asserted at beat 5 of a 4x4 frame -> all outputs 0 immediately; IDLE until the next start.
REQ-040 RASTER_BORDER_FLAG_EN defined, 3x3 frame -> border low only on the centre beat (col 1, row 1).

Source files
------------

// File: rtl/cartoon_pkg.sv
//------------------------------------------------------------------------------
// Module  : cartoon_pkg
// Brief   : Shared state encoding and default widths for the raster generator.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cartoon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int c_def_addr_bits = 20;
    localparam int c_def_col_bits  = 10;
    localparam int c_def_row_bits  = 9;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
//------------------------------------------------------------------------------
// Module  : flex_counter
// Brief   : Enabled up-counter that wraps to zero after reaching a runtime limit.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module flex_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_rollover_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_rollover_flag
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == i_rollover_val) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count         = r_count;
    assign o_rollover_flag = (r_count == i_rollover_val);

endmodule

`default_nettype wire

// File: rtl/raster_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : raster_addr_gen
// Brief   : Raster-order frame-buffer address generator with valid/ready output.
//           Optional border flag output enabled by RASTER_BORDER_FLAG_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module raster_addr_gen
    import cartoon_pkg::*;
#(
    parameter int ADDR_BITS = c_def_addr_bits,
    parameter int COL_BITS  = c_def_col_bits,
    parameter int ROW_BITS  = c_def_row_bits
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COL_BITS-1:0]  img_width,
    input  logic [ROW_BITS-1:0]  img_height,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic                 addr_ready,
    output logic                 addr_valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [COL_BITS-1:0]  col,
    output logic [ROW_BITS-1:0]  row,
    output logic                 line_end,
    output logic                 frame_done,
    output logic                 busy
`ifdef RASTER_BORDER_FLAG_EN
    ,
    output logic                 border
`endif
);

    state_t               r_state;
    logic [COL_BITS-1:0]  r_width;
    logic [ROW_BITS-1:0]  r_height;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_start;
    logic                 w_zero;
    logic                 w_beat;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_final;
    logic [COL_BITS-1:0]  w_col_max;
    logic [ROW_BITS-1:0]  w_row_max;
    logic [COL_BITS-1:0]  w_col;
    logic [ROW_BITS-1:0]  w_row;

    assign w_start   = (r_state == IDLE) && start;
    assign w_zero    = (img_width == '0) || (img_height == '0);
    assign w_beat    = r_valid && addr_ready;
    assign w_final   = w_beat && w_col_last && w_row_last;
    assign w_col_max = r_width - COL_BITS'(1);
    assign w_row_max = r_height - ROW_BITS'(1);

    // Counters restart on every accepted start so a reset-aborted frame leaves no residue.
    flex_counter #(.WIDTH(COL_BITS)) u_col_cnt (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (w_start),
        .i_en            (w_beat),
        .i_rollover_val  (w_col_max),
        .o_count         (w_col),
        .o_rollover_flag (w_col_last)
    );

    flex_counter #(.WIDTH(ROW_BITS)) u_row_cnt (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (w_start),
        .i_en            (w_beat && w_col_last),
        .i_rollover_val  (w_row_max),
        .o_count         (w_row),
        .o_rollover_flag (w_row_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_width  <= '0;
            r_height <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_width  <= img_width;
                        r_height <= img_height;
                        r_addr   <= base_addr;
                        r_busy   <= 1'b1;
                        if (w_zero) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_beat) begin
                        r_addr <= r_addr + ADDR_BITS'(1);
                    end
                    if (w_final) begin
                        r_state <= DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_valid = r_valid;
    assign addr       = r_addr;
    assign col        = w_col;
    assign row        = w_row;
    assign line_end   = r_valid && w_col_last;
    assign frame_done = r_done;
    assign busy       = r_busy;

`ifdef RASTER_BORDER_FLAG_EN
    assign border = r_valid && ((w_row == '0) || w_row_last || (w_col == '0) || w_col_last);
`endif

endmodule

`default_nettype wire

// File: tb/tb_raster_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_raster_addr_gen
// Brief   : Scoreboard bench for raster_addr_gen with a frame-level reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_raster_addr_gen;

    localparam int AB = 20;
    localparam int CB = 10;
    localparam int RB = 9;

    typedef struct packed {
        logic [AB-1:0] a;
        logic [CB-1:0] c;
        logic [RB-1:0] r;
        logic          le;
        logic          last;
        logic          brd;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CB-1:0] img_width = '0;
    logic [RB-1:0] img_height = '0;
    logic [AB-1:0] base_addr = '0;
    logic          addr_ready = 1'b1;
    logic          addr_valid;
    logic [AB-1:0] addr;
    logic [CB-1:0] col;
    logic [RB-1:0] row;
    logic          line_end;
    logic          frame_done;
    logic          busy;
`ifdef RASTER_BORDER_FLAG_EN
    logic          border;
`endif

    int    checks = 0;
    int    failures = 0;
    int    beats_seen = 0;
    bit    ready_rand = 1'b0;
    bit    done_pending = 1'b0;
    bit    hold_active = 1'b0;
    beat_t held;
    beat_t e;
    beat_t exp_q[$];

    raster_addr_gen #(.ADDR_BITS(AB), .COL_BITS(CB), .ROW_BITS(RB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .base_addr  (base_addr),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .addr       (addr),
        .col        (col),
        .row        (row),
        .line_end   (line_end),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef RASTER_BORDER_FLAG_EN
        ,
        .border     (border)
`endif
    );

    always #5 clk = ~clk;

    // Consumer back-pressure, either always ready or randomly stalling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            addr_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: frame_done timing, hold stability and in-order beat comparison.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("frame_done", {31'd0, frame_done}, {31'd0, done_pending});
                done_pending = 1'b0;
                if (hold_active) begin
                    check("hold_valid", {31'd0, addr_valid}, 32'd1);
                    check("hold_addr", {12'd0, addr}, {12'd0, held.a});
                    check("hold_colrow", {13'd0, col, row}, {13'd0, held.c, held.r});
                end
                hold_active = 1'b0;
                if (addr_valid && !addr_ready) begin
                    hold_active = 1'b1;
                    held.a = addr;
                    held.c = col;
                    held.r = row;
                end
                if (addr_valid && addr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_beat: got addr=%h col=%0d row=%0d expected no beat", addr, col, row);
                    end else begin
                        e = exp_q.pop_front();
                        beats_seen++;
                        checks++;
                        if (addr !== e.a || col !== e.c || row !== e.r || line_end !== e.le
`ifdef RASTER_BORDER_FLAG_EN
                            || border !== e.brd
`endif
                        ) begin
                            failures++;
                            $display("FAIL beat: got addr=%h col=%0d row=%0d le=%b expected addr=%h col=%0d row=%0d le=%b",
                                     addr, col, row, line_end, e.a, e.c, e.r, e.le);
                        end
                        if (e.last) done_pending = 1'b1;
                    end
                end else if (!addr_valid && line_end) begin
                    check("line_end_idle", {31'd0, line_end}, 32'd0);
                end
                if (start && !busy && exp_q.size() == 0) done_pending = 1'b1;
            end
        end
    end

    task automatic push_frame(input int w, input int h, input logic [AB-1:0] base);
        beat_t b;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                b.a    = base + AB'(r * w + c);
                b.c    = CB'(c);
                b.r    = RB'(r);
                b.le   = (c == w - 1);
                b.last = (c == w - 1) && (r == h - 1);
                b.brd  = (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start(input int w, input int h, input logic [AB-1:0] base);
        @(posedge clk);
        #1;
        img_width  = CB'(w);
        img_height = RB'(h);
        base_addr  = base;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        img_width  = CB'($urandom);
        img_height = RB'($urandom);
        base_addr  = AB'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (frame_done) break;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no frame_done expected frame_done", name);
        end
        check({name, "_drained"}, exp_q.size(), 32'd0);
        @(negedge clk);
        check({name, "_idle"}, {30'd0, busy, addr_valid}, 32'd0);
    endtask

    task automatic run_frame(input string name, input int w, input int h,
                             input logic [AB-1:0] base, input bit mid_start);
        push_frame(w, h, base);
        pulse_start(w, h, base);
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1;
            img_width  = 10'd2;
            img_height = 9'd1;
            base_addr  = 20'h55555;
            start      = 1'b1;
            @(posedge clk);
            #1;
            start      = 1'b0;
        end
        wait_done(name);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", {addr_valid, line_end, frame_done, busy}, 32'd0);
        check("reset_addr", {12'd0, addr}, 32'd0);
        check("reset_colrow", {13'd0, col, row}, 32'd0);
        rst = 1'b0;

        ready_rand = 1'b0;
        run_frame("f4x2", 4, 2, 20'h00100, 1'b0);
        ready_rand = 1'b1;
        run_frame("f3x1", 3, 1, 20'h00000, 1'b0);
        ready_rand = 1'b0;
        run_frame("f0x5", 0, 5, 20'h00040, 1'b0);
        run_frame("f5x0", 5, 0, 20'h00040, 1'b0);
        run_frame("mid_start", 4, 4, 20'h00200, 1'b1);
        run_frame("f1x1", 1, 1, 20'hFFFFF, 1'b0);
        run_frame("f3x3", 3, 3, 20'h00300, 1'b0);
        ready_rand = 1'b1;
        run_frame("wrap", 5, 3, 20'hFFFF8, 1'b0);

        // Reset mid-frame after five accepted beats.
        ready_rand = 1'b0;
        beats_seen = 0;
        push_frame(4, 4, 20'h00400);
        pulse_start(4, 4, 20'h00400);
        for (int n = 0; n < 100 && beats_seen < 5; n++) @(negedge clk);
        check("rst_reached_beat5", beats_seen, 32'd5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outs", {addr_valid, line_end, frame_done, busy}, 32'd0);
        check("rst_async_addr", {12'd0, addr}, 32'd0);
        check("rst_async_colrow", {13'd0, col, row}, 32'd0);
        exp_q.delete();
        done_pending = 1'b0;
        hold_active  = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_stays_idle", {30'd0, busy, addr_valid}, 32'd0);
        end
        run_frame("after_rst", 4, 4, 20'h00500, 1'b0);

        for (int k = 0; k < 12; k++) begin
            ready_rand = ($urandom_range(0, 1) == 1);
            run_frame("rand", $urandom_range(0, 7), $urandom_range(0, 5), AB'($urandom), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
